// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// feeds IF/ID one instruction per cycle. Optional counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] hold_inst;

    // State, PC and hold buffer; redirect overrides every non-IDLE decision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= '0;
            hold_inst <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (redirect_i) begin
                        pc <= redirect_pc_i;
                        if (!imem_ack_i) begin
                            req_addr <= pc;
                            state    <= DROP;
                        end
                    end else if (imem_ack_i) begin
                        if (stall_i) begin
                            hold_inst <= imem_data_i;
                            state     <= HOLD;
                        end else begin
                            pc <= XLEN'(pc + PC_STEP);
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc        <= redirect_pc_i;
                        hold_inst <= '0;
                        state     <= REQ;
                    end else if (!stall_i) begin
                        pc    <= XLEN'(pc + PC_STEP);
                        state <= REQ;
                    end
                end
                DROP: begin
                    // Old request must complete before a new address can be issued.
                    if (redirect_i) begin
                        pc <= redirect_pc_i;
                    end else if (imem_ack_i) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory request and IF/ID presentation; a zero-wait ack delivers in the same cycle.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        valid_o     = 1'b0;
        pc_o        = '0;
        inst_o      = '0;
        case (state)
            REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc;
                if (imem_ack_i && !redirect_i) begin
                    valid_o = 1'b1;
                    pc_o    = pc;
                    inst_o  = imem_data_i;
                end
            end
            HOLD: begin
                if (!redirect_i) begin
                    valid_o = 1'b1;
                    pc_o    = pc;
                    inst_o  = hold_inst;
                end
            end
            DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = req_addr;
            end
            default: ;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    // Consumed-instruction and bubble counters, free-running modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (valid_o && !stall_i && !redirect_i) begin
                fetch_cnt_o <= XLEN'(fetch_cnt_o + 32'd1);
            end
            if (!valid_o) begin
                bubble_cnt_o <= XLEN'(bubble_cnt_o + 32'd1);
            end
        end
    end
`endif

endmodule
